aes_comp_column_round: RTL
==========================

AES_COMP_COLUMN_ROUND -- requirements
Module: aes_comp_column_round

Interface
REQ-001 SHALL have parameter: IN_BUF, 1, enables a one-entry input holding buffer (0 = no buffer).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: din_valid  input  1  input block valid.
REQ-005 SHALL have port: din_ready  output  1  block accepted when din_valid & din_ready at a CLK edge.
REQ-006 SHALL have port: din  input  128  state after SubBytes/ShiftRows; column c = din[127-32c -: 32], byte 0 of each column in the top byte.
REQ-007 SHALL have port: key  input  128  round key, same column layout, sampled with din.
REQ-008 SHALL have port: final_rnd  input  1  final-round flag, sampled with din.
REQ-009 SHALL have port: dout_valid  output  1  result valid.
REQ-010 SHALL have port: dout_ready  input  1  result consumed when dout_valid & dout_ready at a CLK edge.
REQ-011 SHALL have port: dout  output  128  round result, same layout as din.
REQ-012 SHALL have port: busy  output  1  high whenever the FSM is not IDLE or the buffer is occupied.

Function
REQ-013 SHALL process one 32-bit column per cycle: out_col[c] = MixColumns(in_col[c]) XOR key_col[c], with columns in order 0,1,2,3.
REQ-014 SHALL implement FSM IDLE -> RUN (column counter 0..3) -> DONE; RUN -> DONE after column 3; DONE -> RUN on output handshake if a block is pending, else DONE -> IDLE.
REQ-015 SHALL raise dout_valid exactly 4 CLK edges after the accepting edge when no output stall occurs.
REQ-016 SHALL hold dout and dout_valid stable in DONE until the output handshake.
REQ-017 SHALL drive din_ready high in IDLE; with IN_BUF=1, also whenever the buffer is empty; with IN_BUF=0, only in IDLE.
REQ-018 SHALL, on an input accepted in IDLE, start RUN at column 0 on the next edge and bypass the buffer.
REQ-019 SHALL, on an input accepted while not IDLE (IN_BUF=1), store din, key and final_rnd in the buffer; the buffer is released into RUN on the DONE handshake edge.
REQ-020 SHALL give back-to-back throughput of one block per 5 cycles with dout_ready held high.
REQ-021 SHALL leave dout unchanged (the previous result) while in IDLE and RUN; dout updates only on the edge entering DONE.

Reset
REQ-022 SHALL, while RST is high, force FSM=IDLE, counter=0, buffer empty, dout_valid=0, dout=0, busy=0; din_ready=1 one edge after RST is released.
REQ-023 SHALL discard any in-flight or buffered block on reset mid-operation, with no partial result output.

Configuration
REQ-024 SHALL, with macro AES_FINAL_ROUND_EN defined, compute out_col = in_col XOR key_col (MixColumns bypassed) for blocks sampled with final_rnd=1.
REQ-025 SHALL, without AES_FINAL_ROUND_EN, ignore final_rnd (port kept) and always apply MixColumns.

Structure
REQ-026 SHALL take from the shared AES package: the FSM state enumeration, the column width constant (32) and the column count (4).
REQ-027 SHALL instantiate exactly one sub-module, the existing column-function block AES_Comp_MixColumns, fed from a column mux selected by the counter.

Verification
REQ-028 SHALL check: key=0, every column 0xdb135345 -> dout columns all 0x8e4da1bc, dout_valid 4 edges after acceptance.
REQ-029 SHALL check: key=0, columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5 -> 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6.
REQ-030 SHALL check: din all 0x00, key=0x000102030405060708090a0b0c0d0e0f -> dout equals key.
REQ-031 SHALL check (IN_BUF=1): second block offered during RUN is accepted; dout_ready held low 3 cycles in DONE -> dout stable, din_ready=0, second result follows in order.
REQ-032 SHALL check: RST pulsed at column 2 -> dout_valid=0, dout=0, no stale result after release.
REQ-033 SHALL check (AES_FINAL_ROUND_EN): final_rnd=1, din column 0xdb135345, key=0 -> dout column 0xdb135345.

Source files
------------

// File: rtl/aes_comp_column_round_pkg.sv
// ============================================================================
// Package : aes_comp_column_round_pkg
// Shared AES definitions: FSM state encoding, column geometry and the
// GF(2^8) doubling helper used by the MixColumns column function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_comp_column_round_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  // Multiply a byte by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/AES_Comp_MixColumns.sv
// ============================================================================
// Module  : AES_Comp_MixColumns
// Pure combinational MixColumns on one 32-bit column, byte 0 in the top byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module AES_Comp_MixColumns
  import aes_comp_column_round_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*a is formed as xtime(a) ^ a
  assign col_out = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                    a0 ^ x1 ^ x2 ^ a2 ^ a3,
                    a0 ^ a1 ^ x2 ^ x3 ^ a3,
                    x0 ^ a0 ^ a1 ^ a2 ^ x3};

endmodule

`default_nettype wire

// File: rtl/aes_comp_column_round.sv
// ============================================================================
// Module  : aes_comp_column_round
// One AES round tail (MixColumns + AddRoundKey), one column per cycle, with
// an optional one-entry input holding buffer (IN_BUF).
// Optional feature macro: AES_FINAL_ROUND_EN (final_rnd bypasses MixColumns).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_comp_column_round
  import aes_comp_column_round_pkg::*;
#(
  parameter int IN_BUF = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] din,
  input  logic [127:0] key,
  input  logic         final_rnd,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout,
  output logic         busy
);

  localparam int CNT_W = $clog2(NUM_COLS);
  localparam int BLK_W = COL_W * NUM_COLS;
  localparam int ACC_W = COL_W * (NUM_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

  aes_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d, key_q, key_d, dout_q, dout_d;
  logic [BLK_W-1:0] buf_din_q, buf_din_d, buf_key_q, buf_key_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             fin_q, fin_d, buf_fin_q, buf_fin_d, buf_vld_q, buf_vld_d;
  logic [COL_W-1:0] col_sel, key_sel, col_mix, col_res;
  logic             accept, out_hs, use_mix;

  assign din_ready  = (state_q == IDLE) || ((IN_BUF != 0) && !buf_vld_q);
  assign dout_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE) || buf_vld_q;
  assign dout       = dout_q;
  assign accept     = din_valid && din_ready;
  assign out_hs     = dout_valid && dout_ready;

  // Counter-selected column of the working state and of the round key
  always_comb begin
    col_sel = blk_q[BLK_W-1 -: COL_W];
    key_sel = key_q[BLK_W-1 -: COL_W];
    case (cnt_q)
      2'd1: begin
        col_sel = blk_q[BLK_W-1-COL_W -: COL_W];
        key_sel = key_q[BLK_W-1-COL_W -: COL_W];
      end
      2'd2: begin
        col_sel = blk_q[BLK_W-1-2*COL_W -: COL_W];
        key_sel = key_q[BLK_W-1-2*COL_W -: COL_W];
      end
      2'd3: begin
        col_sel = blk_q[BLK_W-1-3*COL_W -: COL_W];
        key_sel = key_q[BLK_W-1-3*COL_W -: COL_W];
      end
      default: ;
    endcase
  end

  AES_Comp_MixColumns u_mixcol (
    .col_in  (col_sel),
    .col_out (col_mix)
  );

`ifdef AES_FINAL_ROUND_EN
  assign use_mix = !fin_q;
`else
  logic unused_fin;
  assign unused_fin = fin_q;
  assign use_mix    = 1'b1;
`endif

  assign col_res = (use_mix ? col_mix : col_sel) ^ key_sel;

  // Next-state: column sequencing, result assembly and buffer management
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    key_d     = key_q;
    fin_d     = fin_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    buf_din_d = buf_din_q;
    buf_key_d = buf_key_q;
    buf_fin_d = buf_fin_q;
    buf_vld_d = buf_vld_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d   = din;
          key_d   = key;
          fin_d   = final_rnd;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift finished columns in so column 0 ends up in the top slot
        acc_d = {acc_q[ACC_W-COL_W-1:0], col_res};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          dout_d  = {acc_q, col_res};
          state_d = DONE;
        end
        if (accept) begin
          buf_din_d = din;
          buf_key_d = key;
          buf_fin_d = final_rnd;
          buf_vld_d = 1'b1;
        end
      end
      DONE: begin
        if (out_hs) begin
          cnt_d = '0;
          if (buf_vld_q) begin
            blk_d     = buf_din_q;
            key_d     = buf_key_q;
            fin_d     = buf_fin_q;
            buf_vld_d = 1'b0;
            state_d   = RUN;
          end else if (accept) begin
            // Buffer empty: a block arriving on the handshake edge goes straight in
            blk_d   = din;
            key_d   = key;
            fin_d   = final_rnd;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          buf_din_d = din;
          buf_key_d = key;
          buf_fin_d = final_rnd;
          buf_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight or buffered block
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      blk_q     <= '0;
      key_q     <= '0;
      fin_q     <= 1'b0;
      acc_q     <= '0;
      dout_q    <= '0;
      buf_din_q <= '0;
      buf_key_q <= '0;
      buf_fin_q <= 1'b0;
      buf_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      key_q     <= key_d;
      fin_q     <= fin_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      buf_din_q <= buf_din_d;
      buf_key_q <= buf_key_d;
      buf_fin_q <= buf_fin_d;
      buf_vld_q <= buf_vld_d;
    end
  end

endmodule

`default_nettype wire
